// File: rtl/cr_kme_fifo_pfc.sv
// KME staging FIFO: flop storage, show-ahead, programmable stall threshold, sticky errors; CR_KME_FIFO_PFC_BYPASS_EN adds empty bypass.
// Write-to-valid latency 1 cycle (0 with bypass); producer is stalled when free slots <= STALL_AT, writes to a full FIFO are dropped.
module cr_kme_fifo_pfc #(
  parameter int DATA_SIZE   = 263,
  parameter int FIFO_DEPTH  = 4,
  parameter int STALL_AT    = 0,
  parameter bit OVERRIDE_EN = 1'b1,
  parameter int CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [DATA_SIZE-1:0] fifo_in,
  input  logic                 fifo_in_valid,
  output logic                 fifo_in_stall,
  input  logic                 fifo_in_stall_override,
  output logic [DATA_SIZE-1:0] fifo_out,
  output logic                 fifo_out_valid,
  input  logic                 fifo_out_ack,
  output logic [CW-1:0]        used_slots,
  output logic [CW-1:0]        free_slots,
  output logic [CW-1:0]        high_water,
  output logic                 fifo_overflow,
  output logic                 fifo_underflow,
  output logic [1:0]           err_sticky,
  input  logic                 err_clr
);

  localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   STALL_C  = (CW + 1)'(STALL_AT);

  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        used_q, used_d, hw_q, hw_d;
  logic                 ovf_q, ovf_d, udf_q, udf_d;
  logic [1:0]           err_q, err_d;
  logic                 empty, full, byp, byp_take, ren, pop, wen;

  always_comb begin
    empty = (used_q == '0);
    full  = (used_q == DEPTH_C);
`ifdef CR_KME_FIFO_PFC_BYPASS_EN
    byp = empty & fifo_in_valid;
`else
    byp = 1'b0;
`endif
    fifo_out_valid = !empty | byp;
    if (!empty)   fifo_out = mem_q[rd_ptr_q];
    else if (byp) fifo_out = fifo_in;
    else          fifo_out = '0;

    // A bypassed word that is acked never touches storage or counts
    ren      = fifo_out_valid & fifo_out_ack & !clear;
    byp_take = byp & fifo_out_ack;
    pop      = ren & !byp_take;
    wen      = fifo_in_valid & (!full | ren) & !clear & !byp_take;

    used_d   = used_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      used_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wen & !pop)      used_d = used_q + 1'b1;
      else if (pop & !wen) used_d = used_q - 1'b1;
      if (wen) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end

    ovf_d = fifo_in_valid & full & !ren & !clear;
    udf_d = fifo_out_ack & !fifo_out_valid & !clear;
    // New error events override a same-cycle err_clr
    err_d = (err_clr ? 2'b00 : err_q) | {ovf_d, udf_d};
    if (err_clr)              hw_d = used_q;
    else if (used_d > hw_q)   hw_d = used_d;
    else                      hw_d = hw_q;

    used_slots     = used_q;
    free_slots     = DEPTH_C - used_q;
    high_water     = hw_q;
    fifo_overflow  = ovf_q;
    fifo_underflow = udf_q;
    err_sticky     = err_q;
    fifo_in_stall  = ({1'b0, free_slots} <= STALL_C) | (OVERRIDE_EN & fifo_in_stall_override);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      hw_q     <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
      hw_q     <= hw_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      err_q    <= err_d;
    end
  end

  // Payload storage is not reset; fifo_out is masked while empty
  always_ff @(posedge clk) begin
    if (wen) mem_q[wr_ptr_q] <= fifo_in;
  end

endmodule

// File: tb/tb_cr_kme_fifo_pfc.sv
// Directed bench for cr_kme_fifo_pfc: three instances cover depth/threshold/override variants.
module tb_cr_kme_fifo_pfc;
  localparam int DW = 16;

  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, vld = 1'b0, ovr = 1'b0, ack = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] din = '0;
  int checks = 0, errors = 0;

  logic a_stall, a_vld, a_ovf, a_udf, b_stall, b_vld, b_ovf, b_udf, c_stall, c_vld, c_ovf, c_udf;
  logic [DW-1:0] a_out, b_out, c_out;
  logic [2:0] a_used, a_free, a_hw, b_used, b_free, b_hw;
  logic [1:0] c_used, c_free, c_hw, a_err, b_err, c_err;

  cr_kme_fifo_pfc #(.DATA_SIZE(DW), .FIFO_DEPTH(4), .STALL_AT(0), .OVERRIDE_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .fifo_in(din), .fifo_in_valid(vld), .fifo_in_stall(a_stall),
    .fifo_in_stall_override(ovr), .fifo_out(a_out), .fifo_out_valid(a_vld), .fifo_out_ack(ack),
    .used_slots(a_used), .free_slots(a_free), .high_water(a_hw), .fifo_overflow(a_ovf),
    .fifo_underflow(a_udf), .err_sticky(a_err), .err_clr(err_clr));

  cr_kme_fifo_pfc #(.DATA_SIZE(DW), .FIFO_DEPTH(4), .STALL_AT(1), .OVERRIDE_EN(1'b1)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .fifo_in(din), .fifo_in_valid(vld), .fifo_in_stall(b_stall),
    .fifo_in_stall_override(ovr), .fifo_out(b_out), .fifo_out_valid(b_vld), .fifo_out_ack(ack),
    .used_slots(b_used), .free_slots(b_free), .high_water(b_hw), .fifo_overflow(b_ovf),
    .fifo_underflow(b_udf), .err_sticky(b_err), .err_clr(err_clr));

  cr_kme_fifo_pfc #(.DATA_SIZE(DW), .FIFO_DEPTH(3), .STALL_AT(0), .OVERRIDE_EN(1'b0)) u_c (
    .clk(clk), .rst(rst), .clear(clear), .fifo_in(din), .fifo_in_valid(vld), .fifo_in_stall(c_stall),
    .fifo_in_stall_override(ovr), .fifo_out(c_out), .fifo_out_valid(c_vld), .fifo_out_ack(ack),
    .used_slots(c_used), .free_slots(c_free), .high_water(c_hw), .fifo_overflow(c_ovf),
    .fifo_underflow(c_udf), .err_sticky(c_err), .err_clr(err_clr));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vld = 1'b0; ack = 1'b0; clear = 1'b0; err_clr = 1'b0; ovr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (a_used !== 3'd0) begin errors++; $display("FAIL rst_used got %0d exp 0", a_used); end
    checks++; if (a_free !== 3'd4) begin errors++; $display("FAIL rst_free got %0d exp 4", a_free); end
    checks++; if (c_free !== 2'd3) begin errors++; $display("FAIL rst_free_c got %0d exp 3", c_free); end
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", a_vld); end
    checks++; if (a_out !== 16'h0) begin errors++; $display("FAIL rst_out got %0h exp 0", a_out); end
    checks++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b%0b exp 00", a_stall, b_stall); end
    checks++; if (a_err !== 2'b00 || a_hw !== 3'd0) begin errors++; $display("FAIL rst_err_hw got %0b/%0d exp 0/0", a_err, a_hw); end
    checks++; if (a_ovf !== 1'b0 || a_udf !== 1'b0) begin errors++; $display("FAIL rst_pulses got %0b%0b exp 00", a_ovf, a_udf); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vld = 1'b1; din = 16'hA0 + 16'(i);
      cyc();
      checks++; if (a_used !== 3'(i + 1)) begin errors++; $display("FAIL fill_used got %0d exp %0d", a_used, i + 1); end
      checks++; if (a_stall !== (i == 3)) begin errors++; $display("FAIL fill_stall got %0b exp %0b", a_stall, i == 3); end
    end
    vld = 1'b0;
    checks++; if (a_hw !== 3'd4) begin errors++; $display("FAIL fill_hw got %0d exp 4", a_hw); end
    for (int i = 0; i < 4; i++) begin
      ack = 1'b1;
      #1;
      checks++; if (a_vld !== 1'b1 || a_out !== 16'hA0 + 16'(i)) begin errors++; $display("FAIL drain_data got %0b/%0h exp 1/%0h", a_vld, a_out, 16'hA0 + i); end
      cyc();
    end
    ack = 1'b0;
    #1;
    checks++; if (a_vld !== 1'b0 || a_used !== 3'd0) begin errors++; $display("FAIL drain_empty got %0b/%0d exp 0/0", a_vld, a_used); end
    checks++; if (a_hw !== 3'd4) begin errors++; $display("FAIL drain_hw got %0d exp 4", a_hw); end
  endtask

  task automatic test_stall_threshold();
    logic [DW-1:0] exp_q [4];
    exp_q = '{16'hB1, 16'hB2, 16'hB3, 16'hE5};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; din = 16'hB0 + 16'(i);
      cyc();
      checks++; if (b_stall !== (i == 2)) begin errors++; $display("FAIL thr_stall got %0b exp %0b", b_stall, i == 2); end
    end
    checks++; if (b_used !== 3'd3) begin errors++; $display("FAIL thr_used got %0d exp 3", b_used); end
    din = 16'hB3;
    cyc();
    checks++; if (b_used !== 3'd4 || b_ovf !== 1'b0 || b_err !== 2'b00) begin errors++; $display("FAIL thr_4th got %0d/%0b/%0b exp 4/0/00", b_used, b_ovf, b_err); end
    din = 16'hBE;
    cyc();
    checks++; if (b_ovf !== 1'b1 || b_err !== 2'b10 || b_used !== 3'd4) begin errors++; $display("FAIL ovf_pulse got %0b/%0b/%0d exp 1/10/4", b_ovf, b_err, b_used); end
    vld = 1'b0;
    cyc();
    checks++; if (b_ovf !== 1'b0 || b_err !== 2'b10) begin errors++; $display("FAIL ovf_clear got %0b/%0b exp 0/10", b_ovf, b_err); end
    vld = 1'b1; din = 16'hE5; ack = 1'b1;
    #1;
    checks++; if (b_out !== 16'hB0) begin errors++; $display("FAIL full_rw_head got %0h exp b0", b_out); end
    cyc();
    vld = 1'b0;
    checks++; if (b_used !== 3'd4 || b_ovf !== 1'b0) begin errors++; $display("FAIL full_rw got %0d/%0b exp 4/0", b_used, b_ovf); end
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (b_vld !== 1'b1 || b_out !== exp_q[i]) begin errors++; $display("FAIL thr_drain got %0b/%0h exp 1/%0h", b_vld, b_out, exp_q[i]); end
      cyc();
    end
    ack = 1'b0;
    #1;
    checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL thr_empty got %0b exp 0", b_vld); end
  endtask

  task automatic test_wrap();
    do_reset();
    vld = 1'b1; din = 16'hC000;
    cyc();
    for (int i = 1; i <= 10; i++) begin
      din = 16'hC000 + 16'(i); ack = 1'b1;
      #1;
      checks++; if (c_out !== 16'hC000 + 16'(i - 1)) begin errors++; $display("FAIL wrap_data got %0h exp %0h", c_out, 16'hC000 + i - 1); end
      cyc();
      checks++; if (c_used !== 2'd1) begin errors++; $display("FAIL wrap_used got %0d exp 1", c_used); end
    end
    vld = 1'b0;
    #1;
    checks++; if (c_out !== 16'hC00A) begin errors++; $display("FAIL wrap_last got %0h exp c00a", c_out); end
    cyc();
    ack = 1'b0;
    #1;
    checks++; if (c_vld !== 1'b0) begin errors++; $display("FAIL wrap_empty got %0b exp 0", c_vld); end
  endtask

  task automatic test_underflow_clear();
    do_reset();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    checks++; if (a_udf !== 1'b1 || a_err !== 2'b01 || a_used !== 3'd0) begin errors++; $display("FAIL udf_pulse got %0b/%0b/%0d exp 1/01/0", a_udf, a_err, a_used); end
    cyc();
    checks++; if (a_udf !== 1'b0 || a_err !== 2'b01) begin errors++; $display("FAIL udf_clear got %0b/%0b exp 0/01", a_udf, a_err); end
    vld = 1'b1; din = 16'h1;
    cyc();
    din = 16'h2;
    cyc();
    vld = 1'b0; ack = 1'b1;
    checks++; if (a_hw !== 3'd2) begin errors++; $display("FAIL hw2 got %0d exp 2", a_hw); end
    cyc();
    ack = 1'b0; err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    checks++; if (a_err !== 2'b00 || a_hw !== 3'd1) begin errors++; $display("FAIL err_clr got %0b/%0d exp 00/1", a_err, a_hw); end
    ack = 1'b1;
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0; ack = 1'b0;
    checks++; if (a_err !== 2'b01 || a_udf !== 1'b1 || a_hw !== 3'd0) begin errors++; $display("FAIL sticky_wins got %0b/%0b/%0d exp 01/1/0", a_err, a_udf, a_hw); end
    vld = 1'b1; din = 16'h3;
    cyc();
    din = 16'h4;
    cyc();
    checks++; if (a_used !== 3'd2 || a_hw !== 3'd2) begin errors++; $display("FAIL pre_clear got %0d/%0d exp 2/2", a_used, a_hw); end
    clear = 1'b1; ack = 1'b1;
    cyc();
    idle();
    #1;
    checks++; if (a_vld !== 1'b0 || a_used !== 3'd0 || a_free !== 3'd4) begin errors++; $display("FAIL clear got %0b/%0d/%0d exp 0/0/4", a_vld, a_used, a_free); end
    checks++; if (a_ovf !== 1'b0 || a_udf !== 1'b0 || a_err !== 2'b01 || a_hw !== 3'd2) begin errors++; $display("FAIL clear_keep got %0b%0b/%0b/%0d exp 00/01/2", a_ovf, a_udf, a_err, a_hw); end
  endtask

  task automatic test_override();
    do_reset();
    ovr = 1'b1;
    #1;
    checks++; if (a_stall !== 1'b1 || b_stall !== 1'b1) begin errors++; $display("FAIL ovr_en got %0b%0b exp 11", a_stall, b_stall); end
    checks++; if (c_stall !== 1'b0) begin errors++; $display("FAIL ovr_dis got %0b exp 0", c_stall); end
    ovr = 1'b0;
    #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL ovr_off got %0b exp 0", a_stall); end
  endtask

  task automatic test_bypass();
    do_reset();
    vld = 1'b1; din = 16'h5A5A; ack = 1'b1;
    #1;
`ifdef CR_KME_FIFO_PFC_BYPASS_EN
    checks++; if (a_vld !== 1'b1 || a_out !== 16'h5A5A) begin errors++; $display("FAIL byp_comb got %0b/%0h exp 1/5a5a", a_vld, a_out); end
    cyc();
    idle();
    checks++; if (a_used !== 3'd0 || a_udf !== 1'b0) begin errors++; $display("FAIL byp_state got %0d/%0b exp 0/0", a_used, a_udf); end
`else
    checks++; if (a_vld !== 1'b0 || a_out !== 16'h0) begin errors++; $display("FAIL nobyp_comb got %0b/%0h exp 0/0", a_vld, a_out); end
    cyc();
    idle();
    checks++; if (a_used !== 3'd1 || a_udf !== 1'b1 || a_out !== 16'h5A5A) begin errors++; $display("FAIL nobyp_state got %0d/%0b/%0h exp 1/1/5a5a", a_used, a_udf, a_out); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    vld = 1'b1; din = 16'h7;
    cyc();
    cyc();
    vld = 1'b0;
    checks++; if (a_used !== 3'd2) begin errors++; $display("FAIL mid_pre got %0d exp 2", a_used); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_vld !== 1'b0 || a_used !== 3'd0 || a_out !== 16'h0 || a_hw !== 3'd0) begin errors++; $display("FAIL mid_rst got %0b/%0d/%0h/%0d exp 0/0/0/0", a_vld, a_used, a_out, a_hw); end
    cyc();
    rst = 1'b0;
    cyc();
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL post_rst got %0b exp 0", a_vld); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_stall_threshold();
    test_wrap();
    test_underflow_clear();
    test_override();
    test_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
